// File: rtl/pagerank_iter_ctrl_if.sv
// ---------------------------------------------------------------------------
// pagerank_iter_ctrl_if
//   Bundle between the PageRank iteration controller and its environment
//   (ant engines, host and top-K sorter).
//
//   Signal semantics:
//     start, abort   : levels from the host, sampled on each rising clk edge.
//     ant_sync       : per-ant level, 1 = that ant has finished the current
//                      iteration. ant_delta slice i is only looked at while
//                      ant_sync[i] is 1.
//     sync_go        : one-cycle pulse, ants begin the next iteration.
//     sort_start     : one-cycle pulse, top-K sorter may start.
//     busy/done      : status levels. converged/timed_out are only
//                      meaningful while done is high.
//     iter_count     : iterations completed in the current or last run.
//     max_delta      : largest ant_delta captured at the last barrier.
//     dbg_state      : current controller state encoding, for observation.
//
//   Modports:
//     master : environment side (drives start/abort/ant_*)
//     slave  : controller side
// ---------------------------------------------------------------------------
interface pagerank_iter_ctrl_if #(
    parameter int NUM_ANTS = 4,
    parameter int WIDTH    = 16,
    parameter int ITER_W   = 8
);
    logic                      start;
    logic                      abort;
    logic [NUM_ANTS-1:0]       ant_sync;
    logic [NUM_ANTS*WIDTH-1:0] ant_delta;
    logic                      sync_go;
    logic                      busy;
    logic                      done;
    logic                      converged;
    logic                      timed_out;
    logic [ITER_W-1:0]         iter_count;
    logic [WIDTH-1:0]          max_delta;
    logic                      sort_start;
    logic [2:0]                dbg_state;

    modport master (
        output start, abort, ant_sync, ant_delta,
        input  sync_go, busy, done, converged, timed_out,
               iter_count, max_delta, sort_start, dbg_state
    );

    modport slave (
        input  start, abort, ant_sync, ant_delta,
        output sync_go, busy, done, converged, timed_out,
               iter_count, max_delta, sort_start, dbg_state
    );
endinterface

// File: rtl/pagerank_iter_ctrl.sv
// ---------------------------------------------------------------------------
// pagerank_iter_ctrl
//   Iteration/barrier controller for a cluster of NUM_ANTS PageRank ants.
//   Launches iterations with a sync_go pulse, waits until every ant reports
//   completion, records the largest per-ant delta and decides whether to run
//   another iteration. A run ends on convergence (max delta <= EPS), on
//   reaching MAX_ITER iterations, or when one iteration (DRAIN+RUN) exceeds
//   TIMEOUT_CYC cycles. Entering FINISH pulses sort_start for the sorter.
//
// Ports:
//   clk    : rising-edge clock
//   reset  : asynchronous, active-high reset
//   bus    : pagerank_iter_ctrl_if.slave (start/abort/ant_sync/ant_delta in;
//            sync_go/busy/done/converged/timed_out/iter_count/max_delta/
//            sort_start/dbg_state out). All outputs are registered.
// ---------------------------------------------------------------------------
module pagerank_iter_ctrl #(
    parameter int NUM_ANTS    = 4,
    parameter int WIDTH       = 16,
    parameter int EPS         = 2,
    parameter int MAX_ITER    = 64,
    parameter int ITER_W      = 8,
    parameter int TIMEOUT_CYC = 4000,
    parameter int TIMER_W     = 13
) (
    input  logic                  clk,
    input  logic                  reset,
    pagerank_iter_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRAIN  = 3'd1,
        S_RUN    = 3'd2,
        S_EVAL   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    logic                 r_sync_go,    w_sync_go;
    logic                 r_busy,       w_busy;
    logic                 r_done,       w_done;
    logic                 r_converged,  w_converged;
    logic                 r_timed_out,  w_timed_out;
    logic                 r_sort_start, w_sort_start;
    logic [ITER_W-1:0]    r_iter_count, w_iter_count;
    logic [WIDTH-1:0]     r_max_delta,  w_max_delta;
    logic [TIMER_W-1:0]   r_timer,      w_timer;

    logic                 w_barrier;
    logic                 w_drained;
    logic                 w_timer_last;
    logic [WIDTH-1:0]     w_delta_max;
    logic [ITER_W-1:0]    w_iter_inc;

    assign w_barrier    = &bus.ant_sync;
    assign w_drained    = (bus.ant_sync == '0);
    assign w_timer_last = (r_timer == TIMER_W'(TIMEOUT_CYC - 1));

    // Saturating iteration increment.
    assign w_iter_inc = (r_iter_count < ITER_W'(MAX_ITER)) ?
                        (r_iter_count + ITER_W'(1)) : r_iter_count;

    // Unsigned maximum across all ant delta slices.
    always_comb begin
        w_delta_max = '0;
        for (int i = 0; i < NUM_ANTS; i++) begin
            if (bus.ant_delta[i*WIDTH +: WIDTH] > w_delta_max) begin
                w_delta_max = bus.ant_delta[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        w_next_state = r_state;
        w_sync_go    = 1'b0;
        w_iter_count = r_iter_count;
        w_max_delta  = r_max_delta;
        w_converged  = r_converged;
        w_timed_out  = r_timed_out;
        w_timer      = r_timer;

        if (bus.abort) begin
            // Abort beats everything except reset; run results are held.
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_FINISH: begin
                    if (bus.start) begin
                        w_next_state = S_DRAIN;
                        w_sync_go    = 1'b1;
                        w_iter_count = '0;
                        w_max_delta  = '0;
                        w_converged  = 1'b0;
                        w_timed_out  = 1'b0;
                        w_timer      = '0;
                    end
                end
                S_DRAIN: begin
                    // Syncs still high from the previous iteration must
                    // drop before the barrier is armed.
                    w_timer = r_timer + TIMER_W'(1);
                    if (w_timer_last) begin
                        w_timed_out  = 1'b1;
                        w_next_state = S_FINISH;
                    end else if (w_drained) begin
                        w_next_state = S_RUN;
                    end
                end
                S_RUN: begin
                    w_timer = r_timer + TIMER_W'(1);
                    // Barrier is checked first so it wins on the last cycle.
                    if (w_barrier) begin
                        w_max_delta  = w_delta_max;
                        w_next_state = S_EVAL;
                    end else if (w_timer_last) begin
                        w_timed_out  = 1'b1;
                        w_next_state = S_FINISH;
                    end
                end
                S_EVAL: begin
                    w_iter_count = w_iter_inc;
                    if (r_max_delta <= WIDTH'(EPS)) begin
                        w_converged  = 1'b1;
                        w_next_state = S_FINISH;
                    end else if (w_iter_inc == ITER_W'(MAX_ITER)) begin
                        w_next_state = S_FINISH;
                    end else begin
                        w_sync_go    = 1'b1;
                        w_timer      = '0;
                        w_next_state = S_DRAIN;
                    end
                end
                default: begin
                    w_next_state = S_IDLE;
                end
            endcase
        end

        // Status outputs follow the state being entered so they are
        // registered together with it.
        w_busy       = (w_next_state == S_DRAIN) || (w_next_state == S_RUN) ||
                       (w_next_state == S_EVAL);
        w_done       = (w_next_state == S_FINISH);
        w_sort_start = (w_next_state == S_FINISH) && (r_state != S_FINISH);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sync_go    <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_converged  <= 1'b0;
            r_timed_out  <= 1'b0;
            r_sort_start <= 1'b0;
            r_iter_count <= '0;
            r_max_delta  <= '0;
            r_timer      <= '0;
        end else begin
            r_state      <= w_next_state;
            r_sync_go    <= w_sync_go;
            r_busy       <= w_busy;
            r_done       <= w_done;
            r_converged  <= w_converged;
            r_timed_out  <= w_timed_out;
            r_sort_start <= w_sort_start;
            r_iter_count <= w_iter_count;
            r_max_delta  <= w_max_delta;
            r_timer      <= w_timer;
        end
    end

    assign bus.sync_go    = r_sync_go;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.converged  = r_converged;
    assign bus.timed_out  = r_timed_out;
    assign bus.sort_start = r_sort_start;
    assign bus.iter_count = r_iter_count;
    assign bus.max_delta  = r_max_delta;
    assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_pagerank_iter_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pagerank_iter_ctrl
//   Directed bench for pagerank_iter_ctrl. Expected {iter_count,max_delta}
//   at every sync_go and expected run results at every sort_start are pushed
//   into queues by the stimulus; a monitor pops and compares on each pulse.
// ---------------------------------------------------------------------------
module tb_pagerank_iter_ctrl;

    localparam int NUM_ANTS    = 4;
    localparam int WIDTH       = 16;
    localparam int EPS         = 2;
    localparam int MAX_ITER    = 3;
    localparam int ITER_W      = 8;
    localparam int TIMEOUT_CYC = 50;
    localparam int TIMER_W     = 6;

    localparam int SYNC_W = ITER_W + WIDTH;
    localparam int FIN_W  = 2 + ITER_W + WIDTH;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    pagerank_iter_ctrl_if #(.NUM_ANTS(NUM_ANTS), .WIDTH(WIDTH), .ITER_W(ITER_W)) bus ();

    pagerank_iter_ctrl #(
        .NUM_ANTS(NUM_ANTS), .WIDTH(WIDTH), .EPS(EPS), .MAX_ITER(MAX_ITER),
        .ITER_W(ITER_W), .TIMEOUT_CYC(TIMEOUT_CYC), .TIMER_W(TIMER_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [SYNC_W-1:0] exp_sync_q[$];
    logic [FIN_W-1:0]  exp_fin_q[$];
    logic [SYNC_W-1:0] mon_sync_e;
    logic [FIN_W-1:0]  mon_fin_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.sync_go) begin
                if (exp_sync_q.size() == 0) begin
                    check("unexpected_sync_go", 64'd1, 64'd0);
                end else begin
                    mon_sync_e = exp_sync_q.pop_front();
                    check("sync_go_iter_delta", 64'({bus.iter_count, bus.max_delta}),
                          64'(mon_sync_e));
                end
            end
            if (bus.sort_start) begin
                if (exp_fin_q.size() == 0) begin
                    check("unexpected_sort_start", 64'd1, 64'd0);
                end else begin
                    mon_fin_e = exp_fin_q.pop_front();
                    check("finish_conv_to_iter_delta",
                          64'({bus.converged, bus.timed_out, bus.iter_count, bus.max_delta}),
                          64'(mon_fin_e));
                    check("finish_done", 64'(bus.done), 64'd1);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_go(input string name);
        int k = 0;
        @(negedge clk);
        while (!bus.sync_go && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(bus.sync_go), 64'd1);
    endtask

    task automatic wait_fin(input string name);
        int k = 0;
        @(negedge clk);
        while (!bus.sort_start && k < 200) begin
            @(negedge clk);
            k++;
        end
        check(name, 64'(bus.sort_start), 64'd1);
    endtask

    task automatic start_run(input string name);
        bus.start = 1'b1;
        wait_go(name);
        bus.start = 1'b0;
    endtask

    // Drop syncs, let the ants "work" for gap cycles, then all sync.
    task automatic run_iter(input logic [NUM_ANTS*WIDTH-1:0] deltas, input int gap);
        bus.ant_sync = '0;
        tick(gap);
        bus.ant_delta = deltas;
        bus.ant_sync  = '1;
    endtask

    function automatic logic [29:0] all_outs();
        return {bus.sync_go, bus.busy, bus.done, bus.converged, bus.timed_out,
                bus.sort_start, bus.iter_count, bus.max_delta};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int cnt;
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.ant_sync  = '0;
        bus.ant_delta = '0;
        tick(2);
        check("reset_outputs", 64'(all_outs()), 64'd0);
        check("reset_state", 64'(bus.dbg_state), 64'd0);
        reset = 1'b0;
        tick(2);

        // 1: two iterations, max 40 then 2 -> converged after 2
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_sync_q.push_back({8'd1, 16'd40});
        exp_fin_q.push_back({1'b1, 1'b0, 8'd2, 16'd2});
        start_run("t1_go0");
        run_iter({16'd1, 16'd40, 16'd3, 16'd9}, 10);
        wait_go("t1_go1");
        run_iter({16'd2, 16'd0, 16'd1, 16'd2}, 10);
        wait_fin("t1_fin");
        tick(1);
        check("t1_done_held", 64'(bus.done), 64'd1);
        check("t1_sort_start_single", 64'(bus.sort_start), 64'd0);
        check("t1_busy_low", 64'(bus.busy), 64'd0);
        bus.ant_sync = '0;
        tick(2);

        // 2: never converges -> stops at MAX_ITER=3 (started from FINISH)
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_sync_q.push_back({8'd1, 16'd100});
        exp_sync_q.push_back({8'd2, 16'd100});
        exp_fin_q.push_back({1'b0, 1'b0, 8'd3, 16'd100});
        start_run("t2_go0");
        for (int i = 0; i < 3; i++) begin
            run_iter({4{16'd100}}, 3);
            if (i < 2) wait_go("t2_go");
            else       wait_fin("t2_fin");
        end
        bus.ant_sync = '0;
        tick(1);
        check("t2_state_finish", 64'(bus.dbg_state), 64'd4);

        // 3: ant 2 never syncs -> timeout exactly 50 cycles after sync_go
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_fin_q.push_back({1'b0, 1'b1, 8'd0, 16'd0});
        start_run("t3_go0");
        tick(2);
        bus.ant_sync = 4'b1011;
        cnt = 2;
        while (!bus.timed_out && cnt < 200) begin
            tick(1);
            cnt++;
        end
        check("t3_timeout_cycles", 64'(cnt), 64'd50);
        check("t3_sort_start", 64'(bus.sort_start), 64'd1);
        bus.ant_sync = '0;
        tick(2);

        // 4: stale all-1 syncs across sync_go hold the controller in DRAIN
        bus.ant_delta = {4{16'd1}};
        bus.ant_sync  = '1;
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_fin_q.push_back({1'b1, 1'b0, 8'd1, 16'd2});
        start_run("t4_go0");
        tick(20);
        check("t4_state_drain", 64'(bus.dbg_state), 64'd1);
        check("t4_iter_held", 64'({bus.busy, bus.iter_count, bus.max_delta}),
              64'({1'b1, 8'd0, 16'd0}));
        run_iter({16'd1, 16'd0, 16'd2, 16'd1}, 2);
        wait_fin("t4_fin");
        bus.ant_sync = '0;
        tick(2);

        // 5: abort mid-RUN of the second iteration, then restart
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_sync_q.push_back({8'd1, 16'd50});
        start_run("t5_go0");
        run_iter({16'd50, 16'd0, 16'd0, 16'd0}, 2);
        wait_go("t5_go1");
        bus.ant_sync = '0;
        tick(3);
        check("t5_state_run", 64'(bus.dbg_state), 64'd2);
        bus.abort = 1'b1;
        tick(1);
        bus.abort = 1'b0;
        check("t5_state_idle", 64'(bus.dbg_state), 64'd0);
        check("t5_abort_outputs",
              64'({bus.busy, bus.done, bus.sync_go, bus.sort_start, bus.iter_count, bus.max_delta}),
              64'({4'b0000, 8'd1, 16'd50}));
        tick(5);
        check("t5_still_idle", 64'(bus.dbg_state), 64'd0);
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_fin_q.push_back({1'b1, 1'b0, 8'd1, 16'd0});
        start_run("t5_restart_go");
        run_iter({4{16'd0}}, 2);
        wait_fin("t5_fin");
        bus.ant_sync = '0;
        tick(2);

        // 6a: start while busy ignored; barrier on the timeout cycle wins
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_sync_q.push_back({8'd1, 16'd5});
        exp_fin_q.push_back({1'b1, 1'b0, 8'd2, 16'd2});
        start_run("t6_go0");
        tick(3);
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
        tick(45);
        bus.ant_delta = {4{16'd5}};
        bus.ant_sync  = '1;
        tick(1);
        check("t6_no_timeout", 64'({bus.timed_out, bus.busy}), 64'({1'b0, 1'b1}));
        check("t6_state_eval", 64'(bus.dbg_state), 64'd3);
        wait_go("t6_go1");
        run_iter({16'd0, 16'd2, 16'd1, 16'd0}, 2);
        wait_fin("t6_fin");
        bus.ant_sync = '0;
        tick(2);

        // 6b: asynchronous reset mid-RUN clears every output
        exp_sync_q.push_back({8'd0, 16'd0});
        exp_sync_q.push_back({8'd1, 16'd7});
        start_run("t6b_go0");
        run_iter({16'd7, 16'd7, 16'd7, 16'd7}, 2);
        wait_go("t6b_go1");
        bus.ant_sync = '0;
        tick(3);
        #2 reset = 1'b1;
        #1;
        check("t6b_async_reset_outputs", 64'(all_outs()), 64'd0);
        check("t6b_async_reset_state", 64'(bus.dbg_state), 64'd0);
        tick(2);
        reset = 1'b0;
        tick(2);

        check("sync_queue_drained", 64'(exp_sync_q.size()), 64'd0);
        check("fin_queue_drained", 64'(exp_fin_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
